wb_stage_unit: RTL and testbench
================================

Name: wb_stage_unit

Overview:
- Parametrised, registered write-back stage for the RISC-V pipeline.
- Selects one of NUM_SRC result sources, forms PC+PC_INC for the link source, and aligns/sign-extends load data.
- Waits on late load data through a load_valid handshake with timeout, and presents the registered rd/we/data triple to the register file and forwarding unit.
- Honours hazard-unit stall and flush.

Parameters:
- XLEN, 32, datapath width.
- NUM_SRC, 4, number of sources on src_bus (index 0 ALU, 1 PC, 2 load, 3 CSR by default).
- SELW, 2, wb_sel width; requires 2**SELW >= NUM_SRC.
- PC_IDX, 1, source index that receives +PC_INC.
- LOAD_IDX, 2, source index treated as raw load word.
- PC_INC, 4, link increment.
- LD_TIMEOUT, 16, max cycles waiting for load_valid (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  upstream MEM/WB entry valid
- reg_wr  in  1  instruction writes rd
- rd_addr  in  5  destination register
- wb_sel  in  SELW  source select
- src_bus  in  NUM_SRC*XLEN  packed sources, source i at bits [i*XLEN +: XLEN]
- ld_funct3  in  3  load type
- ld_byte_off  in  2  address[1:0] of load
- load_valid  in  1  load word on src_bus[LOAD_IDX] is valid
- stall_in  in  1  hazard-unit freeze
- flush  in  1  squash stage
- stall_req  out  1  stage needs upstream to hold (combinational)
- wb_valid  out  1  registered: committed entry this cycle
- wb_we  out  1  registered regfile write enable
- wb_rd  out  5  registered destination
- wb_data  out  XLEN  registered write data
- ld_timeout  out  1  registered one-cycle error pulse

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset: wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, ld_timeout=0, FSM=IDLE, wait counter=0.
- Priority per edge: rst > flush > stall_in > normal operation.
- Flush: wb_valid<=0, wb_we<=0, ld_timeout<=0, FSM<=IDLE, counter<=0. wb_rd and wb_data hold.
- stall_in=1 (no flush): all state holds, including FSM, counter and outputs. ld_timeout<=0.
- FSM states: IDLE, WAIT_LD.
- IDLE, load entry without data (in_valid & wb_sel==LOAD_IDX & !load_valid): go to WAIT_LD, counter<=1, no commit.
- IDLE, entry with in_valid: commit next edge (1-cycle latency).
- IDLE, no entry: wb_valid<=0, wb_we<=0, other outputs hold.
- WAIT_LD, load_valid=1: commit, go to IDLE.
- WAIT_LD, counter==LD_TIMEOUT without load_valid: wb_valid<=1, wb_we<=0 (write squashed), ld_timeout<=1 for one cycle, go to IDLE.
- WAIT_LD, otherwise: counter++.
- stall_req = (FSM==WAIT_LD) | (IDLE & in_valid & wb_sel==LOAD_IDX & !load_valid). Deasserts in the cycle data arrives or the timeout fires. Upstream holds all inputs stable while stall_req=1.
- Commit: wb_valid<=1, wb_rd<=rd_addr, wb_we<=reg_wr & (rd_addr!=0) & legal sel, wb_data<=selected value.
- Selection: PC_IDX gives src+PC_INC modulo 2**XLEN. LOAD_IDX gives the aligned load. Other legal indices pass through. wb_sel>=NUM_SRC gives data 0 and we 0.
- Load alignment, byte at off*8, half at off[1]*16 (off[0] ignored):
  - 000 LB: byte, sign-extended.
  - 001 LH: half, sign-extended.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - 010 and all others: full word.

Test Plan:
- ALU path: src0=0x0000_1234, sel=0, rd=5, reg_wr=1, in_valid -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234. Next idle cycle wb_valid=0, wb_data holds 0x1234.
- Link/x0: src1=0xFFFF_FFFC, sel=1 -> wb_data=0x0000_0000. Same with rd=0 -> wb_we=0, wb_valid=1.
- Loads, word 0x80F1_7F02 with load_valid=1:
  - LB off=2 -> 0xFFFF_FFF1.
  - LBU off=3 -> 0x0000_0080.
  - LH off=1 -> 0x0000_7F02.
  - LHU off=2 -> 0x0000_80F1.
- Late load: load entry with load_valid low for 3 cycles -> stall_req=1 those 3 cycles. Commit on the edge after load_valid rises; stall_req drops the same cycle.
- Timeout, LD_TIMEOUT=4, load_valid never rises -> after 4 wait cycles: wb_valid=1, wb_we=0, ld_timeout single pulse, FSM back to IDLE.
- Flush/stall: flush while in WAIT_LD -> next cycle stall_req=0, wb_valid=0. stall_in held 2 cycles during a commit -> outputs frozen. rst asserted mid-wait -> all outputs 0.

Source files
------------

// File: rtl/wb_stage_unit.sv
// Registered RISC-V write-back stage: source select, link-address formation and
// load alignment, with a bounded wait for late load data and hazard stall/flush.
module wb_stage_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 4,
  parameter int SELW       = 2,
  parameter int PC_IDX     = 1,
  parameter int LOAD_IDX   = 2,
  parameter int PC_INC     = 4,
  parameter int LD_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    reg_wr,
  input  logic [4:0]              rd_addr,
  input  logic [SELW-1:0]         wb_sel,
  input  logic [NUM_SRC*XLEN-1:0] src_bus,
  input  logic [2:0]              ld_funct3,
  input  logic [1:0]              ld_byte_off,
  input  logic                    load_valid,
  input  logic                    stall_in,
  input  logic                    flush,
  output logic                    stall_req,
  output logic                    wb_valid,
  output logic                    wb_we,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic                    ld_timeout,
  output logic                    dbg_state
);

  localparam int CW = $clog2(LD_TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, WAIT_LD = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] src_val;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] sel_data;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            sel_legal;
  logic            is_load;
  logic            is_pc;
  logic            load_entry;
  logic            at_limit;
  logic            commit_we;

  assign sel_legal  = (int'(wb_sel) < NUM_SRC);
  assign is_load    = (int'(wb_sel) == LOAD_IDX);
  assign is_pc      = (int'(wb_sel) == PC_IDX);
  assign load_entry = in_valid & is_load & ~load_valid;
  assign at_limit   = (wait_cnt == CW'(LD_TIMEOUT));
  assign commit_we  = reg_wr & (rd_addr != 5'd0) & sel_legal;
  assign dbg_state  = (state == WAIT_LD);

  // Released in the cycle the data shows up or the wait expires, so upstream
  // advances on the same edge that commits or aborts the load.
  assign stall_req = (state == WAIT_LD) ? (~load_valid & ~at_limit) : load_entry;

  always_comb begin
    src_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(wb_sel) == i) src_val = src_bus[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    byte_v = src_val[{ld_byte_off, 3'b000} +: 8];
    half_v = ld_byte_off[1] ? src_val[31:16] : src_val[15:0];
    case (ld_funct3)
      3'b000:  load_val = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  load_val = {{(XLEN-16){half_v[15]}}, half_v};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, half_v};
      default: load_val = src_val;
    endcase
  end

  always_comb begin
    if (!sel_legal)   sel_data = '0;
    else if (is_pc)   sel_data = src_val + XLEN'(PC_INC);
    else if (is_load) sel_data = load_val;
    else              sel_data = src_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      ld_timeout <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      ld_timeout <= 1'b0;
    end else if (stall_in) begin
      ld_timeout <= 1'b0;
    end else begin
      ld_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (load_entry) begin
            state    <= WAIT_LD;
            wait_cnt <= CW'(1);
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end else if (in_valid) begin
            wb_valid <= 1'b1;
            wb_we    <= commit_we;
            wb_rd    <= rd_addr;
            wb_data  <= sel_data;
          end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        WAIT_LD: begin
          if (load_valid) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wb_valid <= 1'b1;
            wb_we    <= commit_we;
            wb_rd    <= rd_addr;
            wb_data  <= sel_data;
          end else if (at_limit) begin
            // Retire the entry without a register write and flag the error.
            state      <= IDLE;
            wait_cnt   <= '0;
            wb_valid   <= 1'b1;
            wb_we      <= 1'b0;
            ld_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage_unit.sv
// Bench for wb_stage_unit: directed literal cases followed by constrained-random
// traffic, both checked every cycle against a behavioural write-back model.
module tb_wb_stage_unit;

  localparam int XLEN       = 32;
  localparam int NUM_SRC    = 3;
  localparam int SELW       = 2;
  localparam int PC_IDX     = 1;
  localparam int LOAD_IDX   = 2;
  localparam int PC_INC     = 4;
  localparam int LD_TIMEOUT = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    reg_wr;
  logic [4:0]              rd_addr;
  logic [SELW-1:0]         wb_sel;
  logic [NUM_SRC*XLEN-1:0] src_bus;
  logic [2:0]              ld_funct3;
  logic [1:0]              ld_byte_off;
  logic                    load_valid;
  logic                    stall_in;
  logic                    flush;
  logic                    stall_req;
  logic                    wb_valid;
  logic                    wb_we;
  logic [4:0]              wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic                    ld_timeout;
  logic                    dbg_state;

  wb_stage_unit #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SELW(SELW), .PC_IDX(PC_IDX),
    .LOAD_IDX(LOAD_IDX), .PC_INC(PC_INC), .LD_TIMEOUT(LD_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .reg_wr(reg_wr),
    .rd_addr(rd_addr), .wb_sel(wb_sel), .src_bus(src_bus),
    .ld_funct3(ld_funct3), .ld_byte_off(ld_byte_off), .load_valid(load_valid),
    .stall_in(stall_in), .flush(flush), .stall_req(stall_req),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_timeout(ld_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          wcnt = 0;   // cycles spent waiting for load data, 0 when not waiting
  bit          model_ok = 1'b0;
  logic        m_valid, m_we, m_to, m_new;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [XLEN-1:0] exp_q[$];

  function automatic logic [31:0] ref_data(input int sel, input logic [NUM_SRC*XLEN-1:0] bus,
                                           input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v, b, h;
    if (sel >= NUM_SRC) return 32'h0;
    v = bus[sel*XLEN +: XLEN];
    if (sel == PC_IDX) return v + PC_INC;
    if (sel != LOAD_IDX) return v;
    b = (v >> (8 * int'(off))) & 32'hFF;
    h = off[1] ? (v >> 16) : (v & 32'hFFFF);
    case (f3)
      3'b000:  return (b < 128) ? b : b + 32'hFFFF_FF00;
      3'b001:  return (h < 32768) ? h : h + 32'hFFFF_0000;
      3'b100:  return b;
      3'b101:  return h;
      default: return v;
    endcase
  endfunction

  function automatic bit ref_we();
    return reg_wr && (rd_addr != 0) && (int'(wb_sel) < NUM_SRC);
  endfunction

  function automatic bit exp_stall();
    if (wcnt > 0) return !load_valid && (wcnt != LD_TIMEOUT);
    return in_valid && (int'(wb_sel) == LOAD_IDX) && !load_valid;
  endfunction

  always @(posedge clk) begin
    m_new <= 1'b0;
    if (rst) begin
      model_ok <= 1'b1;
      wcnt <= 0; m_valid <= 1'b0; m_we <= 1'b0; m_to <= 1'b0;
      m_rd <= 5'd0; m_data <= 32'h0;
    end else if (flush) begin
      wcnt <= 0; m_valid <= 1'b0; m_we <= 1'b0; m_to <= 1'b0;
    end else if (stall_in) begin
      m_to <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if ((wcnt > 0 && load_valid) ||
          (wcnt == 0 && in_valid && !(int'(wb_sel) == LOAD_IDX && !load_valid))) begin
        wcnt    <= 0;
        m_valid <= 1'b1;
        m_we    <= ref_we();
        m_rd    <= rd_addr;
        m_data  <= ref_data(int'(wb_sel), src_bus, ld_funct3, ld_byte_off);
        m_new   <= 1'b1;
        if (ref_we()) exp_q.push_back(ref_data(int'(wb_sel), src_bus, ld_funct3, ld_byte_off));
      end else if (wcnt == LD_TIMEOUT) begin
        wcnt <= 0; m_valid <= 1'b1; m_we <= 1'b0; m_to <= 1'b1;
      end else if (wcnt > 0) begin
        wcnt <= wcnt + 1; m_valid <= 1'b0; m_we <= 1'b0;
      end else if (in_valid) begin
        wcnt <= 1; m_valid <= 1'b0; m_we <= 1'b0;
      end else begin
        m_valid <= 1'b0; m_we <= 1'b0;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("wb_valid", wb_valid, m_valid);
      chk("wb_we", wb_we, m_we);
      chk("wb_rd", wb_rd, m_rd);
      chk("wb_data", wb_data, m_data);
      chk("ld_timeout", ld_timeout, m_to);
      chk("stall_req", stall_req, exp_stall());
      chk("dbg_state", dbg_state, wcnt > 0);
      if (m_new && m_we) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
        else chk("sb_write_data", wb_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_bus[i*XLEN +: XLEN] = v;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; reg_wr = 1'b0; rd_addr = 5'd0; wb_sel = '0;
    ld_funct3 = 3'd0; ld_byte_off = 2'd0; load_valid = 1'b0;
    stall_in = 1'b0; flush = 1'b0;
  endtask

  logic [2:0]  ld_f3_t [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ld_off_t[5] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
  logic [31:0] ld_exp_t[5] = '{32'hFFFF_FFF1, 32'h0000_0080, 32'h0000_7F02,
                               32'h0000_80F1, 32'h80F1_7F02};

  initial begin
    rst = 1'b1; src_bus = '0; idle_inputs();
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", wb_valid, 0); chk("rst_we", wb_we, 0); chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0); chk("rst_timeout", ld_timeout, 0);
    chk("rst_stall", stall_req, 0);

    // ALU pass-through and hold on idle
    in_valid = 1'b1; reg_wr = 1'b1; rd_addr = 5'd5; wb_sel = 2'd0; set_src(0, 32'h0000_1234);
    tick();
    chk("alu_valid", wb_valid, 1); chk("alu_we", wb_we, 1);
    chk("alu_rd", wb_rd, 5); chk("alu_data", wb_data, 32'h1234);
    in_valid = 1'b0;
    tick();
    chk("idle_valid", wb_valid, 0); chk("idle_data_hold", wb_data, 32'h1234);

    // link address wraps; x0 destination suppresses the write
    in_valid = 1'b1; wb_sel = 2'd1; rd_addr = 5'd7; set_src(1, 32'hFFFF_FFFC);
    tick();
    chk("link_data", wb_data, 32'h0); chk("link_we", wb_we, 1);
    rd_addr = 5'd0;
    tick();
    chk("x0_valid", wb_valid, 1); chk("x0_we", wb_we, 0);

    // load alignment table
    wb_sel = 2'd2; rd_addr = 5'd3; load_valid = 1'b1; set_src(2, 32'h80F1_7F02);
    for (int k = 0; k < 5; k++) begin
      ld_funct3 = ld_f3_t[k]; ld_byte_off = ld_off_t[k];
      tick();
      chk("load_align", wb_data, ld_exp_t[k]);
    end

    // unused select index writes zero, no write enable
    wb_sel = 2'd3; rd_addr = 5'd9; load_valid = 1'b0;
    tick();
    chk("badsel_valid", wb_valid, 1); chk("badsel_we", wb_we, 0); chk("badsel_data", wb_data, 0);
    in_valid = 1'b0;
    tick();

    // late load: data missing for three cycles
    in_valid = 1'b1; wb_sel = 2'd2; ld_funct3 = 3'b010; ld_byte_off = 2'd0;
    rd_addr = 5'd6; load_valid = 1'b0; set_src(2, 32'hCAFE_F00D);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("late_stall", stall_req, 1); chk("late_novalid", wb_valid, 0);
      tick();
    end
    load_valid = 1'b1;
    settle();
    chk("late_stall_drop", stall_req, 0);
    tick();
    chk("late_valid", wb_valid, 1); chk("late_we", wb_we, 1);
    chk("late_rd", wb_rd, 6); chk("late_data", wb_data, 32'hCAFE_F00D);
    in_valid = 1'b0; load_valid = 1'b0;
    tick();

    // timeout: load data never arrives
    in_valid = 1'b1; rd_addr = 5'd8;
    settle();
    chk("to_entry_stall", stall_req, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("to_wait_pulse", ld_timeout, 0); chk("to_wait_stall", stall_req, 1);
      tick();
    end
    chk("to_last_stall", stall_req, 0); chk("to_last_valid", wb_valid, 0);
    tick();
    in_valid = 1'b0;
    settle();
    chk("to_valid", wb_valid, 1); chk("to_we", wb_we, 0); chk("to_pulse", ld_timeout, 1);
    chk("to_idle", dbg_state, 0); chk("to_data_hold", wb_data, 32'hCAFE_F00D);
    tick();
    chk("to_pulse_end", ld_timeout, 0); chk("to_valid_end", wb_valid, 0);

    // flush while waiting
    in_valid = 1'b1; rd_addr = 5'd12;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    chk("flush_stall", stall_req, 0); chk("flush_valid", wb_valid, 0);
    chk("flush_idle", dbg_state, 0); chk("flush_data_hold", wb_data, 32'hCAFE_F00D);

    // stall_in freezes a committed entry for two cycles
    in_valid = 1'b1; wb_sel = 2'd0; rd_addr = 5'd10; reg_wr = 1'b1; set_src(0, 32'h0000_55AA);
    tick();
    chk("pre_stall_data", wb_data, 32'h55AA);
    set_src(0, 32'h0000_1111); rd_addr = 5'd11; stall_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_valid", wb_valid, 1); chk("stall_rd", wb_rd, 10); chk("stall_data", wb_data, 32'h55AA);
    end
    stall_in = 1'b0;
    tick();
    chk("post_stall_rd", wb_rd, 11); chk("post_stall_data", wb_data, 32'h1111);

    // reset in the middle of a wait
    wb_sel = 2'd2; rd_addr = 5'd13; load_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mrst_valid", wb_valid, 0); chk("mrst_we", wb_we, 0); chk("mrst_rd", wb_rd, 0);
    chk("mrst_data", wb_data, 0); chk("mrst_stall", stall_req, 0); chk("mrst_idle", dbg_state, 0);

    // constrained-random traffic; inputs held while the stage asks for it
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst      = ($urandom_range(0, 399) == 0);
      flush    = ($urandom_range(0, 29) == 0);
      stall_in = ($urandom_range(0, 9) == 0);
      if (exp_stall()) begin
        load_valid = ($urandom_range(0, 3) == 0);
      end else begin
        in_valid    = ($urandom_range(0, 3) != 0);
        reg_wr      = ($urandom_range(0, 3) != 0);
        rd_addr     = 5'($urandom_range(0, 31));
        wb_sel      = SELW'($urandom_range(0, 3));
        src_bus     = {$urandom, $urandom, $urandom};
        ld_funct3   = 3'($urandom_range(0, 7));
        ld_byte_off = 2'($urandom_range(0, 3));
        load_valid  = ($urandom_range(0, 1) == 0);
      end
    end

    // drain
    idle_inputs(); rst = 1'b0; load_valid = 1'b1;
    repeat (4) tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
